// File: rtl/microwave_time_entry.sv
// Keypad time entry for a microwave: debounced digit entry into MM:SS,
// validation on start, and a one-cycle load strobe to the countdown.
module microwave_time_entry #(
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] bcd,
   input  logic       loadn,
   input  logic       clear,
   input  logic       start,
   output logic [3:0] min_tens,
   output logic [3:0] min_units,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_units,
   output logic [2:0] digit_count,
   output logic       locked,
   output logic       load_pulse,
   output logic       entry_error
);

   localparam int unsigned CW = 4;
   localparam logic [1:0] S_EMPTY  = 2'd0;
   localparam logic [1:0] S_ENTRY  = 2'd1;
   localparam logic [1:0] S_FULL   = 2'd2;
   localparam logic [1:0] S_LOCKED = 2'd3;

   logic [CW-1:0] deb_q, deb_d;
   logic [1:0]    state_q, state_d;
   logic [3:0]    min_tens_q, min_tens_d, min_units_q, min_units_d;
   logic [3:0]    sec_tens_q, sec_tens_d, sec_units_q, sec_units_d;
   logic [2:0]    count_q, count_d;
   logic          locked_q, locked_d;
   logic          load_pulse_q, load_pulse_d;
   logic          entry_error_q, entry_error_d;
   logic          key_accept;

   // Debounce saturates at DEBOUNCE so a held key is accepted only once.
   always_comb begin
      deb_d = '0;
      if (loadn) begin
         deb_d = (deb_q == CW'(DEBOUNCE)) ? deb_q : deb_q + CW'(1);
      end
      key_accept = loadn && (deb_q == CW'(DEBOUNCE - 1));
   end

   // Priority: clear, then start, then key accept (start drops a coincident key).
   always_comb begin
      state_d       = state_q;
      min_tens_d    = min_tens_q;
      min_units_d   = min_units_q;
      sec_tens_d    = sec_tens_q;
      sec_units_d   = sec_units_q;
      count_d       = count_q;
      locked_d      = locked_q;
      load_pulse_d  = 1'b0;
      entry_error_d = 1'b0;
      if (clear) begin
         state_d     = S_EMPTY;
         min_tens_d  = '0;
         min_units_d = '0;
         sec_tens_d  = '0;
         sec_units_d = '0;
         count_d     = '0;
         locked_d    = 1'b0;
      end else if (start) begin
         if (state_q == S_ENTRY || state_q == S_FULL) begin
            if (sec_tens_q <= 4'd5) begin
               load_pulse_d = 1'b1;
               locked_d     = 1'b1;
               state_d      = S_LOCKED;
            end else begin
               entry_error_d = 1'b1;
            end
         end
      end else if (key_accept && bcd <= 4'd9 &&
                   (state_q == S_EMPTY || state_q == S_ENTRY)) begin
         min_tens_d  = min_units_q;
         min_units_d = sec_tens_q;
         sec_tens_d  = sec_units_q;
         sec_units_d = bcd;
         count_d     = count_q + 3'd1;
         state_d     = (count_q == 3'd3) ? S_FULL : S_ENTRY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         deb_q         <= '0;
         state_q       <= S_EMPTY;
         min_tens_q    <= '0;
         min_units_q   <= '0;
         sec_tens_q    <= '0;
         sec_units_q   <= '0;
         count_q       <= '0;
         locked_q      <= 1'b0;
         load_pulse_q  <= 1'b0;
         entry_error_q <= 1'b0;
      end else begin
         deb_q         <= deb_d;
         state_q       <= state_d;
         min_tens_q    <= min_tens_d;
         min_units_q   <= min_units_d;
         sec_tens_q    <= sec_tens_d;
         sec_units_q   <= sec_units_d;
         count_q       <= count_d;
         locked_q      <= locked_d;
         load_pulse_q  <= load_pulse_d;
         entry_error_q <= entry_error_d;
      end
   end

   assign min_tens    = min_tens_q;
   assign min_units   = min_units_q;
   assign sec_tens    = sec_tens_q;
   assign sec_units   = sec_units_q;
   assign digit_count = count_q;
   assign locked      = locked_q;
   assign load_pulse  = load_pulse_q;
   assign entry_error = entry_error_q;

endmodule

// File: tb/tb_microwave_time_entry.sv
// Directed bench for microwave_time_entry with DEBOUNCE=4 and
// hand-computed expected values.
module tb_microwave_time_entry;

   logic       clk = 1'b0;
   logic       rst, loadn, clear, start;
   logic [3:0] bcd;
   logic [3:0] min_tens, min_units, sec_tens, sec_units;
   logic [2:0] digit_count;
   logic       locked, load_pulse, entry_error;
   int         checks = 0;
   int         errors = 0;

   microwave_time_entry #(.DEBOUNCE(4)) dut (
      .clk(clk), .rst(rst), .bcd(bcd), .loadn(loadn), .clear(clear), .start(start),
      .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens),
      .sec_units(sec_units), .digit_count(digit_count), .locked(locked),
      .load_pulse(load_pulse), .entry_error(entry_error)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_digits(input string tag, input int mt, input int mu,
                             input int st, input int su, input int cnt);
      chk({tag, ".min_tens"}, int'(min_tens), mt);
      chk({tag, ".min_units"}, int'(min_units), mu);
      chk({tag, ".sec_tens"}, int'(sec_tens), st);
      chk({tag, ".sec_units"}, int'(sec_units), su);
      chk({tag, ".count"}, int'(digit_count), cnt);
   endtask

   task automatic press(input logic [3:0] d);
      bcd = d; loadn = 1'b1;
      tick(4);
      loadn = 1'b0;
      tick(1);
   endtask

   task automatic pulse_clear();
      clear = 1'b1; tick(1); clear = 1'b0;
   endtask

   initial begin
      rst = 1'b1; loadn = 1'b0; clear = 1'b0; start = 1'b0; bcd = 4'd0;
      tick(2);
      rst = 1'b0;
      chk_digits("reset", 0, 0, 0, 0, 0);
      chk("reset.locked", int'(locked), 0);
      chk("reset.load_pulse", int'(load_pulse), 0);
      chk("reset.entry_error", int'(entry_error), 0);

      // Three high samples are not enough; the fourth accepts once.
      bcd = 4'd7; loadn = 1'b1; tick(3);
      chk("deb3.count", int'(digit_count), 0);
      loadn = 1'b0; tick(1);
      loadn = 1'b1; tick(3);
      chk("deb_again3.count", int'(digit_count), 0);
      tick(1);
      chk_digits("deb4", 0, 0, 0, 7, 1);
      tick(3);
      chk("deb_hold.count", int'(digit_count), 1);
      loadn = 1'b0; tick(1);
      pulse_clear(); tick(1);

      press(4'd1); press(4'd2); press(4'd3); press(4'd0);
      chk_digits("full", 1, 2, 3, 0, 4);
      press(4'd5);
      chk_digits("full_ignore", 1, 2, 3, 0, 4);
      pulse_clear(); tick(1);
      chk_digits("clear_full", 0, 0, 0, 0, 0);
      press(4'hB);
      chk("bcd_gt9.count", int'(digit_count), 0);

      press(4'd1); press(4'd7); press(4'd5);
      start = 1'b1; tick(1); start = 1'b0;
      chk("bad.entry_error", int'(entry_error), 1);
      chk("bad.load_pulse", int'(load_pulse), 0);
      chk("bad.locked", int'(locked), 0);
      chk_digits("bad", 0, 1, 7, 5, 3);
      tick(1);
      chk("bad_next.entry_error", int'(entry_error), 0);
      pulse_clear(); tick(1);
      chk_digits("clear_bad", 0, 0, 0, 0, 0);

      press(4'd4); press(4'd5);
      start = 1'b1; tick(1); start = 1'b0;
      chk("good.load_pulse", int'(load_pulse), 1);
      chk("good.locked", int'(locked), 1);
      chk("good.entry_error", int'(entry_error), 0);
      tick(1);
      chk("good_next.load_pulse", int'(load_pulse), 0);
      press(4'd9);
      chk_digits("locked_key", 0, 0, 4, 5, 2);
      start = 1'b1; tick(1); start = 1'b0;
      chk("locked_start.load_pulse", int'(load_pulse), 0);
      chk("locked_start.locked", int'(locked), 1);
      pulse_clear(); tick(1);
      chk("unlock.locked", int'(locked), 0);

      press(4'd3);
      start = 1'b1; clear = 1'b1; tick(1); start = 1'b0; clear = 1'b0;
      chk("start_clear.load_pulse", int'(load_pulse), 0);
      chk("start_clear.locked", int'(locked), 0);
      chk_digits("start_clear", 0, 0, 0, 0, 0);
      tick(1);
      chk("start_clear_next.load_pulse", int'(load_pulse), 0);

      start = 1'b1; tick(1); start = 1'b0;
      chk("empty_start.load_pulse", int'(load_pulse), 0);
      chk("empty_start.entry_error", int'(entry_error), 0);

      // Reset mid-debounce drops progress; four fresh samples are needed.
      press(4'd8);
      bcd = 4'd3; loadn = 1'b1; tick(2);
      rst = 1'b1; tick(1); rst = 1'b0;
      chk_digits("rst_mid", 0, 0, 0, 0, 0);
      chk("rst_mid.locked", int'(locked), 0);
      tick(3);
      chk("rst_rel3.count", int'(digit_count), 0);
      tick(1);
      chk_digits("rst_rel4", 0, 0, 0, 3, 1);
      loadn = 1'b0; tick(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
